// File: rtl/usb_fifo_bridge_pkg.sv
// rtl/usb_fifo_bridge_pkg.sv - shared types and constants for the USB FIFO bridge
package usb_fifo_pkg;

   localparam int CNT_W                = 11;
   localparam int WR_PULSE_CYC_DEF     = 2;
   localparam int RD_PULSE_CYC_DEF     = 3;
   localparam int RECOVERY_CYC_DEF     = 3;
   localparam int WAIT_TIMEOUT_CYC_DEF = 1024;

   localparam logic [7:0] ERR_READ_DATA = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_WAIT, ST_WR_PULSE, ST_RD_WAIT,
      ST_RD_PULSE, ST_SIWU_PULSE, ST_ACK, ST_RECOVER
   } state_e;

   typedef enum logic [1:0] {
      REQ_WR, REQ_RD, REQ_SIWU
   } req_kind_e;

   // Saturating increment so a stuck wait can never wrap back into range.
   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/usb_fifo_bridge_sync2.sv
// rtl/usb_fifo_bridge_sync2.sv - parameterised-width two-flop synchroniser, resets high
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/usb_fifo_bridge.sv
// rtl/usb_fifo_bridge.sv - drives FT245-style FIFO pins from glue decode strobes
module usb_fifo_bridge
   import usb_fifo_pkg::*;
#(
   parameter int WR_PULSE_CYC     = WR_PULSE_CYC_DEF,
   parameter int RD_PULSE_CYC     = RD_PULSE_CYC_DEF,
   parameter int RECOVERY_CYC     = RECOVERY_CYC_DEF,
   parameter int WAIT_TIMEOUT_CYC = WAIT_TIMEOUT_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_req_n,
   input  logic       rd_req_n,
   input  logic       siwu_req_n,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_rdata_oe,
   output logic       ack_n,
   output logic       txe_sync_n,
   output logic       rxf_sync_n,
   output logic       err_flag,
   input  logic [7:0] ft_d_in,
   output logic [7:0] ft_d_out,
   output logic       ft_d_oe,
   output logic       ft_wr_n,
   output logic       ft_rd_n,
   output logic       ft_siwu_n,
   input  logic       ft_txe_n,
   input  logic       ft_rxf_n
);

   logic wr_s_n, rd_s_n, siwu_s_n, req_released;

   sync2 #(.W(5)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({wr_req_n, rd_req_n, siwu_req_n, ft_txe_n, ft_rxf_n}),
      .q   ({wr_s_n, rd_s_n, siwu_s_n, txe_sync_n, rxf_sync_n})
   );

   state_e          state_q, state_d;
   req_kind_e       kind_q, kind_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            wr_n_q, wr_n_d, rd_n_q, rd_n_d, siwu_n_q, siwu_n_d;
   logic            d_oe_q, d_oe_d, rdata_oe_q, rdata_oe_d, ack_n_q, ack_n_d, err_q, err_d;
   logic [7:0]      d_out_q, d_out_d, rdata_q, rdata_d;

   always_comb begin
      case (kind_q)
         REQ_WR:  req_released = wr_s_n;
         REQ_RD:  req_released = rd_s_n;
         default: req_released = siwu_s_n;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      cnt_d      = cnt_q;
      wr_n_d     = wr_n_q;
      rd_n_d     = rd_n_q;
      siwu_n_d   = siwu_n_q;
      d_oe_d     = d_oe_q;
      d_out_d    = d_out_q;
      rdata_d    = rdata_q;
      rdata_oe_d = rdata_oe_q;
      ack_n_d    = ack_n_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!wr_s_n) begin
               kind_d  = REQ_WR;
               d_out_d = cpu_wdata;
               d_oe_d  = 1'b1;
               state_d = ST_WR_WAIT;
            end else if (!rd_s_n) begin
               kind_d  = REQ_RD;
               state_d = ST_RD_WAIT;
            end else if (!siwu_s_n) begin
               kind_d   = REQ_SIWU;
               siwu_n_d = 1'b0;
               cnt_d    = CNT_W'(1);
               state_d  = ST_SIWU_PULSE;
            end
         end
         ST_WR_WAIT: begin
            if (!txe_sync_n) begin
               wr_n_d  = 1'b0;
               cnt_d   = CNT_W'(1);
               state_d = ST_WR_PULSE;
            end else if (cnt_q == CNT_W'(WAIT_TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               d_oe_d  = 1'b0;
               ack_n_d = 1'b0;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_WR_PULSE: begin
            if (cnt_q == CNT_W'(WR_PULSE_CYC)) begin
               wr_n_d  = 1'b1;
               ack_n_d = 1'b0;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_RD_WAIT: begin
            if (!rxf_sync_n) begin
               rd_n_d  = 1'b0;
               cnt_d   = CNT_W'(1);
               state_d = ST_RD_PULSE;
            end else if (cnt_q == CNT_W'(WAIT_TIMEOUT_CYC - 1)) begin
               rdata_d    = ERR_READ_DATA;
               err_d      = 1'b1;
               ack_n_d    = 1'b0;
               rdata_oe_d = 1'b1;
               state_d    = ST_ACK;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_RD_PULSE: begin
            if (cnt_q == CNT_W'(RD_PULSE_CYC)) begin
               rd_n_d     = 1'b1;
               rdata_d    = ft_d_in;
               ack_n_d    = 1'b0;
               rdata_oe_d = 1'b1;
               state_d    = ST_ACK;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_SIWU_PULSE: begin
            if (cnt_q == CNT_W'(WR_PULSE_CYC)) begin
               siwu_n_d = 1'b1;
               ack_n_d  = 1'b0;
               state_d  = ST_ACK;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         ST_ACK: begin
            // Data bus released one cycle after the write strobe rises.
            d_oe_d = 1'b0;
            if (req_released) begin
               ack_n_d    = 1'b1;
               rdata_oe_d = 1'b0;
               cnt_d      = '0;
               state_d    = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == CNT_W'(RECOVERY_CYC - 1)) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         kind_q     <= REQ_WR;
         cnt_q      <= '0;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         siwu_n_q   <= 1'b1;
         d_oe_q     <= 1'b0;
         d_out_q    <= 8'h00;
         rdata_q    <= ERR_READ_DATA;
         rdata_oe_q <= 1'b0;
         ack_n_q    <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         cnt_q      <= cnt_d;
         wr_n_q     <= wr_n_d;
         rd_n_q     <= rd_n_d;
         siwu_n_q   <= siwu_n_d;
         d_oe_q     <= d_oe_d;
         d_out_q    <= d_out_d;
         rdata_q    <= rdata_d;
         rdata_oe_q <= rdata_oe_d;
         ack_n_q    <= ack_n_d;
         err_q      <= err_d;
      end
   end

   assign ft_wr_n      = wr_n_q;
   assign ft_rd_n      = rd_n_q;
   assign ft_siwu_n    = siwu_n_q;
   assign ft_d_oe      = d_oe_q;
   assign ft_d_out     = d_out_q;
   assign cpu_rdata    = rdata_q;
   assign cpu_rdata_oe = rdata_oe_q;
   assign ack_n        = ack_n_q;
   assign err_flag     = err_q;

endmodule

// File: tb/tb_usb_fifo_bridge.sv
// tb/tb_usb_fifo_bridge.sv - directed self-checking bench for usb_fifo_bridge
module tb_usb_fifo_bridge;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_req_n, rd_req_n, siwu_req_n;
   logic [7:0] cpu_wdata, cpu_rdata, ft_d_in, ft_d_out;
   logic       cpu_rdata_oe, ack_n, txe_sync_n, rxf_sync_n, err_flag;
   logic       ft_d_oe, ft_wr_n, ft_rd_n, ft_siwu_n, ft_txe_n, ft_rxf_n;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   usb_fifo_bridge dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req_n     (wr_req_n),
      .rd_req_n     (rd_req_n),
      .siwu_req_n   (siwu_req_n),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_rdata_oe (cpu_rdata_oe),
      .ack_n        (ack_n),
      .txe_sync_n   (txe_sync_n),
      .rxf_sync_n   (rxf_sync_n),
      .err_flag     (err_flag),
      .ft_d_in      (ft_d_in),
      .ft_d_out     (ft_d_out),
      .ft_d_oe      (ft_d_oe),
      .ft_wr_n      (ft_wr_n),
      .ft_rd_n      (ft_rd_n),
      .ft_siwu_n    (ft_siwu_n),
      .ft_txe_n     (ft_txe_n),
      .ft_rxf_n     (ft_rxf_n)
   );

   // FIFO-side pin monitor: pulse widths, start/end cycles, latched bytes and bus rules.
   int wr_len = 0, rd_len = 0, siwu_len = 0;
   int wr_lens[$], wr_starts[$], wr_ends[$], wr_bytes[$];
   int rd_lens[$], siwu_lens[$], siwu_starts[$];
   int both_low = 0, oe_bad = 0, hold_bad = 0;

   always @(negedge clk) begin
      if (!ft_wr_n && !ft_rd_n) both_low++;
      if (!ft_wr_n) begin
         if (wr_len == 0) begin
            wr_starts.push_back(cyc);
            wr_bytes.push_back(int'(ft_d_out));
         end
         if (!ft_d_oe) oe_bad++;
         wr_len++;
      end else if (wr_len != 0) begin
         wr_lens.push_back(wr_len);
         wr_ends.push_back(cyc);
         if (!ft_d_oe) hold_bad++;
         wr_len = 0;
      end
      if (!ft_rd_n) begin
         if (ft_d_oe) oe_bad++;
         rd_len++;
      end else if (rd_len != 0) begin
         rd_lens.push_back(rd_len);
         rd_len = 0;
      end
      if (!ft_siwu_n) begin
         if (siwu_len == 0) siwu_starts.push_back(cyc);
         siwu_len++;
      end else if (siwu_len != 0) begin
         siwu_lens.push_back(siwu_len);
         siwu_len = 0;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ack(input logic lvl, input int budget, output int n);
      n = 0;
      while (ack_n !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
   endtask

   function automatic int last_of(input int q[$]);
      return (q.size() == 0) ? -1 : q[q.size()-1];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n, c0, nwr, ns, nrd;
      rst = 1'b0; wr_req_n = 1'b1; rd_req_n = 1'b1; siwu_req_n = 1'b1;
      cpu_wdata = 8'h00; ft_d_in = 8'h00; ft_txe_n = 1'b1; ft_rxf_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_wr_n", int'(ft_wr_n), 1);
      chk("rst_rd_n", int'(ft_rd_n), 1);
      chk("rst_siwu_n", int'(ft_siwu_n), 1);
      chk("rst_d_oe", int'(ft_d_oe), 0);
      chk("rst_d_out", int'(ft_d_out), 8'h00);
      chk("rst_rdata", int'(cpu_rdata), 8'hFF);
      chk("rst_rdata_oe", int'(cpu_rdata_oe), 0);
      chk("rst_ack_n", int'(ack_n), 1);
      chk("rst_err", int'(err_flag), 0);
      chk("rst_txe_sync", int'(txe_sync_n), 1);

      rst = 1'b1; ft_txe_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("txe_sync_low", int'(txe_sync_n), 0);
      chk("rxf_sync_high", int'(rxf_sync_n), 1);

      // Single write, FIFO ready
      c0 = cyc; cpu_wdata = 8'hA5; wr_req_n = 1'b0;
      wait_ack(1'b0, 50, n);
      chk("wr_ack", int'(ack_n), 0);
      chk("wr_count", wr_lens.size(), 1);
      chk("wr_width", last_of(wr_lens), 2);
      chk("wr_byte", last_of(wr_bytes), 8'hA5);
      chk("wr_d_out", int'(ft_d_out), 8'hA5);
      chk("wr_lat_min", int'(last_of(wr_starts) - c0 >= 3), 1);
      chk("wr_err", int'(err_flag), 0);
      wr_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      chk("wr_ack_release_cyc", n, 3);
      repeat (6) @(negedge clk);

      // Read, FIFO has data
      ft_d_in = 8'h3C; ft_rxf_n = 1'b0;
      repeat (3) @(negedge clk);
      rd_req_n = 1'b0;
      wait_ack(1'b0, 50, n);
      chk("rd_ack", int'(ack_n), 0);
      chk("rd_data", int'(cpu_rdata), 8'h3C);
      chk("rd_oe_in_ack", int'(cpu_rdata_oe), 1);
      chk("rd_width", last_of(rd_lens), 3);
      rd_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      chk("rd_ack_rel", int'(ack_n), 1);
      chk("rd_oe_after", int'(cpu_rdata_oe), 0);
      ft_rxf_n = 1'b1;
      repeat (6) @(negedge clk);

      // Write timeout with TXE held high
      ft_txe_n = 1'b1;
      repeat (3) @(negedge clk);
      nwr = wr_lens.size(); cpu_wdata = 8'h5A; wr_req_n = 1'b0;
      repeat (1000) @(negedge clk);
      chk("to_err_early", int'(err_flag), 0);
      chk("to_ack_early", int'(ack_n), 1);
      repeat (100) @(negedge clk);
      chk("to_err_set", int'(err_flag), 1);
      chk("to_ack", int'(ack_n), 0);
      chk("to_no_strobe", wr_lens.size() + wr_len, nwr);
      chk("to_d_oe", int'(ft_d_oe), 0);
      wr_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      ft_txe_n = 1'b0;
      repeat (6) @(negedge clk);
      cpu_wdata = 8'h11; wr_req_n = 1'b0;
      wait_ack(1'b0, 50, n);
      chk("after_to_byte", last_of(wr_bytes), 8'h11);
      chk("err_sticky", int'(err_flag), 1);
      wr_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      repeat (6) @(negedge clk);

      // Back-to-back writes
      nwr = wr_lens.size(); cpu_wdata = 8'h21; wr_req_n = 1'b0;
      wait_ack(1'b0, 50, n);
      wr_req_n = 1'b1;
      @(negedge clk);
      cpu_wdata = 8'h22; wr_req_n = 1'b0;
      wait_ack(1'b1, 10, n);
      wait_ack(1'b0, 60, n);
      chk("b2b_ack", int'(ack_n), 0);
      chk("b2b_count", wr_lens.size(), nwr + 2);
      if (wr_lens.size() >= nwr + 2) begin
         chk("b2b_byte0", wr_bytes[nwr], 8'h21);
         chk("b2b_byte1", wr_bytes[nwr+1], 8'h22);
         chk("b2b_gap_ok", int'(wr_starts[nwr+1] - wr_ends[nwr] >= 6), 1);
      end
      wr_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      repeat (6) @(negedge clk);

      // Simultaneous write and send-immediate: write wins
      ns = siwu_lens.size(); cpu_wdata = 8'h77;
      wr_req_n = 1'b0; siwu_req_n = 1'b0;
      wait_ack(1'b0, 50, n);
      chk("prio_wr_byte", last_of(wr_bytes), 8'h77);
      chk("prio_no_siwu", siwu_lens.size() + siwu_len, ns);
      wr_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      wait_ack(1'b0, 60, n);
      chk("prio_siwu_ack", int'(ack_n), 0);
      chk("prio_siwu_count", siwu_lens.size(), ns + 1);
      chk("prio_siwu_width", last_of(siwu_lens), 2);
      siwu_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      repeat (6) @(negedge clk);

      // Send-immediate latency from an idle bridge
      c0 = cyc; siwu_req_n = 1'b0;
      wait_ack(1'b0, 50, n);
      chk("siwu_latency", last_of(siwu_starts) - c0, 3);
      siwu_req_n = 1'b1;
      wait_ack(1'b1, 10, n);
      repeat (6) @(negedge clk);

      // Reset asserted in the middle of a read pulse
      ft_d_in = 8'h99; ft_rxf_n = 1'b0;
      repeat (3) @(negedge clk);
      rd_req_n = 1'b0;
      n = 0;
      while (ft_rd_n !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mid_rd_low_seen", int'(ft_rd_n), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("mid_rst_async_rd_n", int'(ft_rd_n), 1);
      rd_req_n = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_rd_n", int'(ft_rd_n), 1);
      chk("post_rst_rdata", int'(cpu_rdata), 8'hFF);
      chk("post_rst_ack", int'(ack_n), 1);
      chk("post_rst_err", int'(err_flag), 0);
      chk("post_rst_rdata_oe", int'(cpu_rdata_oe), 0);
      nrd = rd_lens.size();
      repeat (20) @(negedge clk);
      chk("post_rst_no_strobe", rd_lens.size() + rd_len, nrd);

      chk("never_both_low", both_low, 0);
      chk("d_oe_rules", oe_bad, 0);
      chk("d_oe_hold", hold_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
